// File: rtl/time_counters.sv
// BCD seconds/minutes/hours timekeeping datapath with a 1 Hz time base and a set-mode stepper.
// Field strobes and mode come from the clock control FSM; outputs feed the display multiplexer.
module time_counters #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SET_DIV  = 12500000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Counters_Reset,
  input  logic       i_Counters_Enable_Increment,
  input  logic [2:0] i_Counters_Enable_Count,
  output logic [7:0] o_Seconds,
  output logic [7:0] o_Minutes,
  output logic [7:0] o_Hours,
  output logic       o_Second_Tick,
  output logic       o_Half_Second
);

  localparam int unsigned TbW  = $clog2(TICK_DIV);
  localparam int unsigned SetW = (SET_DIV > 1) ? $clog2(SET_DIV) : 1;

  logic [TbW-1:0]  tb_cnt_q, tb_cnt_d;
  logic [SetW-1:0] set_cnt_q, set_cnt_d;
  logic [7:0]      sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic            sec_tick_q, sec_tick_d;
  logic            tick, set_step, sec_carry, min_carry;

  // Wrap is detected on the full BCD byte so illegal codes can never be reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick     = (tb_cnt_q == TbW'(TICK_DIV - 1));
  assign set_step = (set_cnt_q == SetW'(SET_DIV - 1));

  always_comb begin
    tb_cnt_d   = tb_cnt_q;
    set_cnt_d  = '0;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_tick_d = 1'b0;
    sec_carry  = 1'b0;
    min_carry  = 1'b0;
    if (i_Counters_Reset) begin
      tb_cnt_d = '0;
      sec_d    = 8'h00;
    end else begin
      tb_cnt_d = tick ? '0 : tb_cnt_q + TbW'(1);
      if (i_Counters_Enable_Increment) begin
        // Set mode: each enabled field steps on its own, no carries between fields.
        set_cnt_d = set_step ? '0 : set_cnt_q + SetW'(1);
        if (set_step) begin
          if (i_Counters_Enable_Count[0]) sec_d = bcd_inc(sec_q, 8'h59);
          if (i_Counters_Enable_Count[1]) min_d = bcd_inc(min_q, 8'h59);
          if (i_Counters_Enable_Count[2]) hr_d  = bcd_inc(hr_q, 8'h23);
        end
      end else begin
        sec_tick_d = tick;
        if (tick) begin
          // A disabled field absorbs the incoming carry.
          if (i_Counters_Enable_Count[0]) begin
            sec_d     = bcd_inc(sec_q, 8'h59);
            sec_carry = (sec_q == 8'h59);
          end
          if (i_Counters_Enable_Count[1] && sec_carry) begin
            min_d     = bcd_inc(min_q, 8'h59);
            min_carry = (min_q == 8'h59);
          end
          if (i_Counters_Enable_Count[2] && min_carry) hr_d = bcd_inc(hr_q, 8'h23);
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tb_cnt_q   <= '0;
      set_cnt_q  <= '0;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hr_q       <= 8'h00;
      sec_tick_q <= 1'b0;
    end else begin
      tb_cnt_q   <= tb_cnt_d;
      set_cnt_q  <= set_cnt_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign o_Seconds     = sec_q;
  assign o_Minutes     = min_q;
  assign o_Hours       = hr_q;
  assign o_Second_Tick = sec_tick_q;
  assign o_Half_Second = (tb_cnt_q < TbW'(TICK_DIV / 2));

endmodule

// File: tb/tb_time_counters.sv
// Directed bench for time_counters: per-cycle check against an integer-arithmetic clock model,
// plus hand-computed literal expectations at key points.
module tb_time_counters;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned SetDiv  = 3;

  logic       clk = 1'b0;
  logic       rst, crst, inc;
  logic [2:0] en;
  logic [7:0] sec, mins, hrs;
  logic       stick, half;

  int total = 0;
  int bad   = 0;

  time_counters #(
    .TICK_DIV(TickDiv),
    .SET_DIV (SetDiv)
  ) dut (
    .i_Clock                    (clk),
    .i_Reset                    (rst),
    .i_Counters_Reset           (crst),
    .i_Counters_Enable_Increment(inc),
    .i_Counters_Enable_Count    (en),
    .o_Seconds                  (sec),
    .o_Minutes                  (mins),
    .o_Hours                    (hrs),
    .o_Second_Tick              (stick),
    .o_Half_Second              (half)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int   s;
    int   m;
    int   h;
    int   tb;
    int   sc;
    logic tick;
    logic valid;
  } mstate_t;

  mstate_t mdl = '0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  // Clock model in plain integer time arithmetic.
  function automatic mstate_t model_next(input mstate_t c, input logic r, input logic cr,
                                         input logic in, input logic [2:0] e);
    mstate_t n;
    logic    t;
    n = c;
    if (r) begin
      n       = '0;
      n.valid = 1'b1;
      return n;
    end
    n.tick = 1'b0;
    if (cr) begin
      n.s  = 0;
      n.tb = 0;
      n.sc = 0;
      return n;
    end
    t    = (c.tb == int'(TickDiv) - 1);
    n.tb = (c.tb + 1) % int'(TickDiv);
    if (in) begin
      n.sc = c.sc + 1;
      if (n.sc == int'(SetDiv)) begin
        n.sc = 0;
        if (e[0]) n.s = (c.s + 1) % 60;
        if (e[1]) n.m = (c.m + 1) % 60;
        if (e[2]) n.h = (c.h + 1) % 24;
      end
    end else begin
      n.sc   = 0;
      n.tick = t;
      if (t && e[0]) begin
        n.s = c.s + 1;
        if (n.s == 60) begin
          n.s = 0;
          if (e[1]) begin
            n.m = c.m + 1;
            if (n.m == 60) begin
              n.m = 0;
              if (e[2]) n.h = (c.h + 1) % 24;
            end
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) mdl <= model_next(mdl, rst, crst, inc, en);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mdl.valid) begin
      chk("model_sec", sec, to_bcd(mdl.s));
      chk("model_min", mins, to_bcd(mdl.m));
      chk("model_hr", hrs, to_bcd(mdl.h));
      chk("model_tick", {7'd0, stick}, {7'd0, mdl.tick});
      chk("model_half", {7'd0, half}, {7'd0, (mdl.tb < int'(TickDiv / 2))});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({name, "_hr"}, hrs, h);
    chk({name, "_min"}, mins, m);
    chk({name, "_sec"}, sec, s);
  endtask

  initial begin
    rst  = 1'b1;
    crst = 1'b0;
    inc  = 1'b0;
    en   = 3'b000;
    step(2);
    rst = 1'b0;
    en  = 3'b111;

    // 1: reset state and first tick
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_tick", {7'd0, stick}, 8'h00);
    chk("reset_half", {7'd0, half}, 8'h01);
    for (int k = 1; k < 4; k++) begin
      step(1);
      chk("t1_half", {7'd0, half}, (k < 2) ? 8'h01 : 8'h00);
      chk("t1_notick", {7'd0, stick}, 8'h00);
      chk("t1_sec0", sec, 8'h00);
    end
    step(1);
    chk("t1_sec1", sec, 8'h01);
    chk("t1_tick", {7'd0, stick}, 8'h01);
    chk("t1_half_wrap", {7'd0, half}, 8'h01);
    step(1);
    chk("t1_tick_once", {7'd0, stick}, 8'h00);

    // 2: full rollover
    inc = 1'b1;
    en  = 3'b100;
    step(69);
    chk_time("t2_set_hr", 8'h23, 8'h00, 8'h01);
    en = 3'b010;
    step(177);
    chk_time("t2_set_min", 8'h23, 8'h59, 8'h01);
    inc  = 1'b0;
    en   = 3'b111;
    crst = 1'b1;
    step(1);
    crst = 1'b0;
    chk("t2_crst", sec, 8'h00);
    step(236);
    chk_time("t2_pre", 8'h23, 8'h59, 8'h59);
    step(3);
    chk_time("t2_hold", 8'h23, 8'h59, 8'h59);
    step(1);
    chk_time("t2_roll", 8'h00, 8'h00, 8'h00);
    chk("t2_tick", {7'd0, stick}, 8'h01);

    // 3: counters reset at 12:34:37
    inc = 1'b1;
    en  = 3'b100;
    step(36);
    en = 3'b010;
    step(102);
    en = 3'b001;
    step(111);
    chk_time("t3_pre", 8'h12, 8'h34, 8'h37);
    inc  = 1'b0;
    en   = 3'b111;
    crst = 1'b1;
    step(10);
    chk_time("t3_held", 8'h12, 8'h34, 8'h00);
    chk("t3_notick", {7'd0, stick}, 8'h00);
    crst = 1'b0;
    step(3);
    chk("t3_sec0", sec, 8'h00);
    step(1);
    chk("t3_sec1", sec, 8'h01);

    // 4: set minutes without carry
    inc = 1'b1;
    en  = 3'b100;
    step(57);
    en = 3'b010;
    step(72);
    chk_time("t4_pre", 8'h07, 8'h58, 8'h01);
    step(2);
    chk("t4_e2", mins, 8'h58);
    step(1);
    chk("t4_e3", mins, 8'h59);
    step(3);
    chk_time("t4_e6", 8'h07, 8'h00, 8'h01);
    step(3);
    chk_time("t4_e9", 8'h07, 8'h01, 8'h01);
    chk("t4_notick", {7'd0, stick}, 8'h00);

    // 5: set hours wrap, then resume normal mode
    en = 3'b100;
    step(45);
    chk("t5_pre", hrs, 8'h22);
    step(3);
    chk("t5_23", hrs, 8'h23);
    step(3);
    chk_time("t5_00", 8'h00, 8'h01, 8'h01);
    inc = 1'b0;
    en  = 3'b111;
    step(2);
    chk("t5_wait", sec, 8'h01);
    step(1);
    chk("t5_resume", sec, 8'h02);
    chk("t5_tick", {7'd0, stick}, 8'h01);

    // 6: reset during set mode
    inc = 1'b1;
    en  = 3'b100;
    step(45);
    en = 3'b010;
    step(123);
    en = 3'b001;
    step(24);
    chk_time("t6_pre", 8'h15, 8'h42, 8'h10);
    rst = 1'b1;
    step(1);
    chk_time("t6_rst", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    inc = 1'b0;
    en  = 3'b111;
    step(3);
    chk("t6_sec0", sec, 8'h00);
    chk("t6_notick", {7'd0, stick}, 8'h00);
    step(1);
    chk("t6_sec1", sec, 8'h01);
    chk("t6_tick", {7'd0, stick}, 8'h01);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
